pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_pkg.sv | 21 ++
 rtl/hazard_match.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipe_hazard_pkg;

    // Widest register address the scoreboard entry can hold; narrower addresses are zero-extended.
    localparam int MAX_REG_AW = 8;

    localparam int FSEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  regwrite;
        logic                  load;
    } sb_entry_t;

    // Stage at whose end a writer's result can be forwarded.
    function automatic int unsigned ready_stage(input logic is_load, input int unsigned load_stage);
        return is_load ? load_stage : 32'd1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search of the in-flight writers for one source operand; the youngest match wins.
module hazard_match
    import pipe_hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FSEL_W     = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:1]   sb_i,
    input  logic [MAX_REG_AW-1:0]   addr_i,
    input  logic                    use_i,
    output logic                    hit_o,
    output logic [FSEL_W-1:0]       stage_o,
    output logic [FSEL_W-1:0]       ready_o
);

    always_comb begin
        hit_o   = 1'b0;
        stage_o = '0;
        ready_o = '0;
        // Walk oldest to youngest so the lowest matching stage is the last assignment.
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (use_i && (addr_i != '0) && sb_i[k].valid && sb_i[k].regwrite &&
                (sb_i[k].rd == addr_i)) begin
                hit_o   = 1'b1;
                stage_o = FSEL_W'(k);
                ready_o = FSEL_W'(ready_stage(sb_i[k].load, LOAD_STAGE));
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall and redirect flush for the MIPS pipeline.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FSEL_W     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_load_i,
    input  logic              redirect_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              bubble_o,
    output logic [FSEL_W-1:0] fwd_a_sel_o,
    output logic [FSEL_W-1:0] fwd_b_sel_o,
    output logic              ex_valid_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    sb_entry_t [DEPTH:1] sb;

    logic              a_hit, b_hit;
    logic [FSEL_W-1:0] a_stage, a_ready, b_stage, b_ready;
    logic              hazard;
    logic              sb_wb_unused;

    hazard_match #(
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .FSEL_W     (FSEL_W)
    ) u_match_rs (
        .sb_i    (sb[DEPTH-1:1]),
        .addr_i  (MAX_REG_AW'(id_rs_i)),
        .use_i   (id_use_rs_i),
        .hit_o   (a_hit),
        .stage_o (a_stage),
        .ready_o (a_ready)
    );

    hazard_match #(
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .FSEL_W     (FSEL_W)
    ) u_match_rt (
        .sb_i    (sb[DEPTH-1:1]),
        .addr_i  (MAX_REG_AW'(id_rt_i)),
        .use_i   (id_use_rt_i),
        .hit_o   (b_hit),
        .stage_o (b_stage),
        .ready_o (b_ready)
    );

    // The WB entry is tracked but never searched: the write-through register file covers it.
    assign sb_wb_unused = ^sb[DEPTH];

    assign hazard   = (a_hit && (a_ready > a_stage)) || (b_hit && (b_ready > b_stage));
    assign flush_o  = redirect_i;
    assign stall_o  = !rst_i && !redirect_i && (!start_i || hazard);
    assign bubble_o = !rst_i && (redirect_i || !start_i || hazard);

    assign ex_valid_o = sb[1].valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb          <= '0;
            fwd_a_sel_o <= FSEL_W'(FSEL_RF);
            fwd_b_sel_o <= FSEL_W'(FSEL_RF);
        end else if (start_i) begin
            sb[DEPTH:2] <= sb[DEPTH-1:1];
            if (bubble_o) begin
                sb[1] <= '0;
            end else begin
                sb[1] <= '{valid: 1'b1, rd: MAX_REG_AW'(id_rd_i),
                           regwrite: id_regwrite_i, load: id_load_i};
            end
            fwd_a_sel_o <= (bubble_o || !a_hit) ? FSEL_W'(FSEL_RF) : a_stage;
            fwd_b_sel_o <= (bubble_o || !b_hit) ? FSEL_W'(FSEL_RF) : b_stage;
        end else begin
            fwd_a_sel_o <= FSEL_W'(FSEL_RF);
            fwd_b_sel_o <= FSEL_W'(FSEL_RF);
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (flush_o && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against an age-based model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW     = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int FSEL_W     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [REG_AW-1:0] rs = '0, rt = '0, rd = '0;
    logic              use_rs = 1'b0, use_rt = 1'b0, regwrite = 1'b0, load = 1'b0, redirect = 1'b0;
    logic              stall_o, flush_o, bubble_o, ex_valid_o;
    logic [FSEL_W-1:0] fwd_a_sel_o, fwd_b_sel_o;
`ifdef HAZARD_PERF_EN
    logic [31:0]       stall_cnt_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW (REG_AW), .DEPTH (DEPTH), .LOAD_STAGE (LOAD_STAGE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .id_rs_i       (rs),
        .id_rt_i       (rt),
        .id_use_rs_i   (use_rs),
        .id_use_rt_i   (use_rt),
        .id_rd_i       (rd),
        .id_regwrite_i (regwrite),
        .id_load_i     (load),
        .redirect_i    (redirect),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .bubble_o      (bubble_o),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o),
        .ex_valid_o    (ex_valid_o)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: in-flight instructions with their age in post-decode stages (1 = EX).
    typedef struct {
        logic [REG_AW-1:0] rd;
        bit                rw;
        bit                ld;
        int                age;
    } inst_t;

    inst_t q[$];
    bit    m_stall, m_flush, m_bubble, m_ex_valid;
    int    m_sel_a, m_sel_b, nxt_a, nxt_b;

    function automatic void find(input logic [REG_AW-1:0] a, input bit use_it,
                                 output bit hit, output int age, output int rdy);
        hit = 0; age = 0; rdy = 0;
        if (!use_it || a == 0) return;
        foreach (q[i]) begin
            if (q[i].age < DEPTH && q[i].rw && q[i].rd == a && (!hit || q[i].age < age)) begin
                hit = 1;
                age = q[i].age;
                rdy = q[i].ld ? LOAD_STAGE : 1;
            end
        end
    endfunction

    task automatic model_reset();
        q.delete();
        m_ex_valid = 0; m_sel_a = 0; m_sel_b = 0; nxt_a = 0; nxt_b = 0;
    endtask

    task automatic model_comb();
        bit ha, hb, hz;
        int aa, ab, ra, rb;
        find(rs, use_rs, ha, aa, ra);
        find(rt, use_rt, hb, ab, rb);
        hz       = (ha && ra > aa) || (hb && rb > ab);
        m_flush  = redirect;
        m_stall  = !rst && !redirect && (!start || hz);
        m_bubble = !rst && (redirect || !start || hz);
        nxt_a    = (m_bubble || !ha) ? 0 : aa;
        nxt_b    = (m_bubble || !hb) ? 0 : ab;
    endtask

    task automatic model_clock();
        if (start) begin
            foreach (q[i]) q[i].age++;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].age > DEPTH) q.delete(i);
            if (!m_bubble) q.push_back('{rd: rd, rw: regwrite, ld: load, age: 1});
            m_ex_valid = 0;
            foreach (q[i]) if (q[i].age == 1) m_ex_valid = 1;
            m_sel_a = nxt_a;
            m_sel_b = nxt_b;
        end else begin
            m_sel_a = 0;
            m_sel_b = 0;
        end
    endtask

    task automatic apply(input bit st, input logic [REG_AW-1:0] a_rs, input bit a_urs,
                         input logic [REG_AW-1:0] a_rt, input bit a_urt,
                         input logic [REG_AW-1:0] a_rd, input bit a_rw, input bit a_ld,
                         input bit a_redir);
        start = st; rs = a_rs; use_rs = a_urs; rt = a_rt; use_rt = a_urt;
        rd = a_rd; regwrite = a_rw; load = a_ld; redirect = a_redir;
        #2;
        model_comb();
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 0; use_rs = 0; use_rt = 0; regwrite = 0; load = 0; redirect = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        redirect = 1'b1;
        #2;
        n_cmp += 5;
        if (flush_o !== 1'b1) begin n_fail++; $display("FAIL reset_flush got %b want 1", flush_o); end
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_o); end
        if (bubble_o !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b want 0", bubble_o); end
        if (fwd_a_sel_o !== '0 || fwd_b_sel_o !== '0) begin
            n_fail++; $display("FAIL reset_sel got %0d/%0d want 0/0", fwd_a_sel_o, fwd_b_sel_o);
        end
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %b want 0", ex_valid_o); end
        do_reset();
    endtask

    task automatic test_fwd_alu();
        do_reset();
        apply(1, 1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        apply(1, 3, 1, 2, 1, 9, 1, 0, 0);
        n_cmp++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b want 0", stall_o); end
        tick();
        n_cmp += 2;
        if (fwd_a_sel_o !== 2'd1) begin n_fail++; $display("FAIL alu_sel_a got %0d want 1", fwd_a_sel_o); end
        if (fwd_b_sel_o !== 2'd0) begin n_fail++; $display("FAIL alu_sel_b got %0d want 0", fwd_b_sel_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        apply(1, 1, 1, 2, 0, 4, 1, 1, 0);
        tick();
        apply(1, 4, 1, 0, 0, 10, 1, 0, 0);
        n_cmp += 2;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall_o); end
        if (bubble_o !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got %b want 1", bubble_o); end
        tick();
        n_cmp++;
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL lu_ex_bubble got %b want 0", ex_valid_o); end
        apply(1, 4, 1, 0, 0, 10, 1, 0, 0);
        n_cmp++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b want 0", stall_o); end
        tick();
        n_cmp += 2;
        if (fwd_a_sel_o !== 2'd2) begin n_fail++; $display("FAIL lu_sel got %0d want 2", fwd_a_sel_o); end
        if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL lu_ex_valid got %b want 1", ex_valid_o); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        apply(1, 1, 0, 1, 0, 0, 1, 0, 0);
        tick();
        apply(1, 0, 1, 0, 1, 11, 1, 0, 0);
        n_cmp++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL zero_stall got %b want 0", stall_o); end
        tick();
        n_cmp++;
        if (fwd_a_sel_o !== '0 || fwd_b_sel_o !== '0) begin
            n_fail++; $display("FAIL zero_sel got %0d/%0d want 0/0", fwd_a_sel_o, fwd_b_sel_o);
        end
    endtask

    task automatic test_youngest();
        do_reset();
        apply(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        apply(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        apply(1, 5, 1, 5, 1, 12, 1, 0, 0);
        n_cmp++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL young_stall got %b want 0", stall_o); end
        tick();
        n_cmp++;
        if (fwd_a_sel_o !== 2'd1 || fwd_b_sel_o !== 2'd1) begin
            n_fail++; $display("FAIL young_sel got %0d/%0d want 1/1", fwd_a_sel_o, fwd_b_sel_o);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        apply(1, 0, 0, 0, 0, 6, 1, 1, 0);
        tick();
        apply(1, 6, 1, 0, 0, 12, 1, 0, 1);
        n_cmp += 3;
        if (flush_o !== 1'b1) begin n_fail++; $display("FAIL redir_flush got %b want 1", flush_o); end
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL redir_stall got %b want 0", stall_o); end
        if (bubble_o !== 1'b1) begin n_fail++; $display("FAIL redir_bubble got %b want 1", bubble_o); end
        tick();
        n_cmp += 2;
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_ex_valid got %b want 0", ex_valid_o); end
        if (fwd_a_sel_o !== '0) begin n_fail++; $display("FAIL redir_sel got %0d want 0", fwd_a_sel_o); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        apply(1, 0, 0, 0, 0, 8, 1, 0, 0);
        tick();
        apply(1, 8, 1, 0, 0, 7, 1, 1, 0);
        tick();
        n_cmp++;
        if (fwd_a_sel_o !== 2'd1) begin n_fail++; $display("FAIL rms_pre_sel got %0d want 1", fwd_a_sel_o); end
        apply(1, 7, 1, 0, 0, 13, 1, 0, 0);
        n_cmp++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rms_pre_stall got %b want 1", stall_o); end
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp += 3;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rms_stall got %b want 0", stall_o); end
        if (fwd_a_sel_o !== '0) begin n_fail++; $display("FAIL rms_sel got %0d want 0", fwd_a_sel_o); end
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rms_ex_valid got %b want 0", ex_valid_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1, 7, 1, 8, 1, 14, 1, 0, 0);
        n_cmp++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rms_after_stall got %b want 0", stall_o); end
        tick();
        n_cmp++;
        if (fwd_a_sel_o !== '0 || fwd_b_sel_o !== '0) begin
            n_fail++; $display("FAIL rms_after_sel got %0d/%0d want 0/0", fwd_a_sel_o, fwd_b_sel_o);
        end
    endtask

    task automatic test_start_low();
        do_reset();
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        apply(0, 3, 1, 0, 0, 15, 1, 0, 0);
        n_cmp += 2;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL idle_stall got %b want 1", stall_o); end
        if (bubble_o !== 1'b1) begin n_fail++; $display("FAIL idle_bubble got %b want 1", bubble_o); end
        tick();
        n_cmp++;
        if (fwd_a_sel_o !== '0) begin n_fail++; $display("FAIL idle_sel got %0d want 0", fwd_a_sel_o); end
        apply(1, 3, 1, 0, 0, 15, 1, 0, 0);
        tick();
        n_cmp++;
        if (fwd_a_sel_o !== 2'd1) begin n_fail++; $display("FAIL idle_resume_sel got %0d want 1", fwd_a_sel_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            apply($urandom_range(0, 19) != 0,
                  REG_AW'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  REG_AW'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                  REG_AW'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            n_cmp += 3;
            if (stall_o !== m_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d got %b want %b", c, stall_o, m_stall); end
            if (flush_o !== m_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d got %b want %b", c, flush_o, m_flush); end
            if (bubble_o !== m_bubble) begin n_fail++; $display("FAIL rnd_bubble c=%0d got %b want %b", c, bubble_o, m_bubble); end
            tick();
            n_cmp += 3;
            if (fwd_a_sel_o !== FSEL_W'(m_sel_a)) begin n_fail++; $display("FAIL rnd_sel_a c=%0d got %0d want %0d", c, fwd_a_sel_o, m_sel_a); end
            if (fwd_b_sel_o !== FSEL_W'(m_sel_b)) begin n_fail++; $display("FAIL rnd_sel_b c=%0d got %0d want %0d", c, fwd_b_sel_o, m_sel_b); end
            if (ex_valid_o !== m_ex_valid) begin n_fail++; $display("FAIL rnd_ex_valid c=%0d got %b want %b", c, ex_valid_o, m_ex_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_zero_reg();
        test_youngest();
        test_redirect();
        test_reset_mid_stall();
        test_start_low();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
